// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: TDM 1-to-4 demultiplexer that rebuilds four channels from a slot-ordered serial stream.
// Optional build macro TDM_STRICT_SYNC_EN: in LOCK a slot-0 sample without frame_sync
// raises sync_err and drops back to HUNT; otherwise the slot counter flywheels.
module tdm_demux_1x4 #(
    parameter int W   = 1,
    parameter int FCW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [W-1:0]   y0,
    output logic [W-1:0]   y1,
    output logic [W-1:0]   y2,
    output logic [W-1:0]   y3,
    output logic           y_valid,
    output logic [1:0]     slot,
    output logic           locked,
    output logic           sync_err,
    output logic [FCW-1:0] frame_cnt
);
    typedef enum logic {HUNT, LOCK} state_t;

    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [W-1:0]   s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [W-1:0]   y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
    logic           y_valid_q, y_valid_d;
    logic           sync_err_q, sync_err_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

    // Next-state: capture samples into shadows by slot, publish the whole frame on slot 3.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        y3_d        = y3_q;
        y_valid_d   = 1'b0;
        sync_err_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (din_valid) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    s0_d    = din;
                    slot_d  = 2'd1;
                    state_d = LOCK;
                end
            end else if (frame_sync && slot_q != 2'd0) begin
                // Misplaced sync: abandon the partial frame and restart at slot 0.
                sync_err_d = 1'b1;
                s0_d       = din;
                slot_d     = 2'd1;
            end else if (slot_q == 2'd0) begin
`ifdef TDM_STRICT_SYNC_EN
                if (frame_sync) begin
                    s0_d   = din;
                    slot_d = 2'd1;
                end else begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                    slot_d     = 2'd0;
                end
`else
                s0_d   = din;
                slot_d = 2'd1;
`endif
            end else if (slot_q == 2'd1) begin
                s1_d   = din;
                slot_d = 2'd2;
            end else if (slot_q == 2'd2) begin
                s2_d   = din;
                slot_d = 2'd3;
            end else begin
                y0_d        = s0_q;
                y1_d        = s1_q;
                y2_d        = s2_q;
                y3_d        = din;
                y_valid_d   = 1'b1;
                frame_cnt_d = frame_cnt_q + FCW'(1);
                slot_d      = 2'd0;
            end
        end
    end

    // State and datapath registers; reset drops any partial frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            y3_q        <= '0;
            y_valid_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            y3_q        <= y3_d;
            y_valid_q   <= y_valid_d;
            sync_err_q  <= sync_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign y0        = y0_q;
    assign y1        = y1_q;
    assign y2        = y2_q;
    assign y3        = y3_q;
    assign y_valid   = y_valid_q;
    assign slot      = slot_q;
    assign locked    = (state_q == LOCK);
    assign sync_err  = sync_err_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4: scoreboard bench for tdm_demux_1x4 with W=8, FCW=8.
module tb_tdm_demux_1x4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] y0, y1, y2, y3, frame_cnt;
    logic       y_valid, locked, sync_err;
    logic [1:0] slot;

    int total = 0;
    int bad = 0;
    int serr_seen = 0;
    int exp_serr = 0;
    logic [7:0] exp_cnt = '0;
    logic [39:0] sb[$];

    tdm_demux_1x4 #(.W(8), .FCW(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .y_valid(y_valid), .slot(slot), .locked(locked), .sync_err(sync_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sample on the next rising edge, then optional idle gap cycles.
    task automatic sample(input logic [7:0] d, input logic fs, input int gap);
        din = d;
        frame_sync = fs;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_frame(input logic [7:0] a, b, c, d);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back({a, b, c, d, exp_cnt});
    endtask

    task automatic frame(input logic [7:0] a, b, c, d, input logic fs0, input logic exp_out);
        if (exp_out) expect_frame(a, b, c, d);
        sample(a, fs0, 0);
        sample(b, 1'b0, 0);
        sample(c, 1'b0, 0);
        sample(d, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a completed frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_err) serr_seen++;
            if (y_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_y_valid: got y=%h %h %h %h cnt=%0d expected no frame", y0, y1, y2, y3, frame_cnt);
                end else begin
                    logic [39:0] e;
                    e = sb.pop_front();
                    chk("y0", 32'(y0), 32'(e[39:32]));
                    chk("y1", 32'(y1), 32'(e[31:24]));
                    chk("y2", 32'(y2), 32'(e[23:16]));
                    chk("y3", 32'(y3), 32'(e[15:8]));
                    chk("frame_cnt", 32'(frame_cnt), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        #2;
        chk("rst_y0", 32'(y0), 0);
        chk("rst_y3", 32'(y3), 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_slot", 32'(slot), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        do_reset();

        frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b1);
        chk("t1_y_valid_hi", 32'(y_valid), 1);
        chk("t1_locked", 32'(locked), 1);
        chk("t1_slot", 32'(slot), 0);
        @(posedge clk);
        #1;
        chk("t1_y_valid_lo", 32'(y_valid), 0);
        chk("t1_hold_y0", 32'(y0), 32'h11);

        do_reset();
        sample(8'hAA, 1'b0, 0);
        sample(8'hBB, 1'b0, 0);
        chk("t2_hunt_slot", 32'(slot), 0);
        chk("t2_hunt_locked", 32'(locked), 0);
        frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1);
        #5;
        chk("t2_sync_err_cnt", 32'(serr_seen), 32'(exp_serr));

        sample(8'hA0, 1'b1, 0);
        sample(8'hA1, 1'b0, 0);
        exp_serr++;
        expect_frame(8'h55, 8'h66, 8'h77, 8'h88);
        sample(8'h55, 1'b1, 0);
        chk("t3_sync_err", 32'(sync_err), 1);
        chk("t3_slot_restart", 32'(slot), 1);
        chk("t3_y0_unchanged", 32'(y0), 32'h01);
        sample(8'h66, 1'b0, 0);
        chk("t3_sync_err_pulse", 32'(sync_err), 0);
        sample(8'h77, 1'b0, 0);
        sample(8'h88, 1'b0, 0);
        chk("t3_slot_end", 32'(slot), 0);

        expect_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        sample(8'h9A, 1'b1, 1);
        sample(8'hBC, 1'b0, 2);
        chk("t4_slot_hold", 32'(slot), 2);
        sample(8'hDE, 1'b0, 3);
        chk("t4_slot_hold3", 32'(slot), 3);
        sample(8'hF0, 1'b0, 0);
        @(posedge clk);
        #1;

`ifdef TDM_STRICT_SYNC_EN
        exp_serr++;
        sample(8'h10, 1'b0, 0);
        chk("t6_strict_sync_err", 32'(sync_err), 1);
        chk("t6_strict_locked", 32'(locked), 0);
        sample(8'h20, 1'b0, 0);
        sample(8'h30, 1'b0, 0);
        sample(8'h40, 1'b0, 0);
        chk("t6_strict_slot", 32'(slot), 0);
`else
        frame(8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 1'b1);
        chk("t6_fly_locked", 32'(locked), 1);
        chk("t6_fly_y_valid", 32'(y_valid), 1);
`endif
        @(posedge clk);
        #1;
        chk("t6_sync_err_cnt", 32'(serr_seen), 32'(exp_serr));

        do_reset();
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            frame(v, v + 8'd1, v + 8'd2, v + 8'd3, 1'b1, 1'b1);
        end
        chk("t5_wrap_cnt", 32'(frame_cnt), 0);
        chk("t5_wrap_y0", 32'(y0), 32'hFF);

        sample(8'hE1, 1'b1, 0);
        sample(8'hE2, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_y0", 32'(y0), 0);
        chk("t7_rst_y1", 32'(y1), 0);
        chk("t7_rst_y2", 32'(y2), 0);
        chk("t7_rst_y3", 32'(y3), 0);
        chk("t7_rst_cnt", 32'(frame_cnt), 0);
        chk("t7_rst_locked", 32'(locked), 0);
        chk("t7_rst_slot", 32'(slot), 0);
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b0, 1'b0);
        chk("t7_post_locked", 32'(locked), 0);
        chk("t7_post_slot", 32'(slot), 0);
        chk("t7_post_cnt", 32'(frame_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        chk("final_sync_err_cnt", 32'(serr_seen), 32'(exp_serr));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Time-division demultiplexer; the receive-side inverse of the 4-to-1 channel selector.
- Takes a serial stream in which a 4:1 mux sends channel samples in slot order 0,1,2,3, repeating, with a frame marker on slot 0.
- Rebuilds the four parallel channels into registered outputs and pulses a strobe once per complete frame.
- Sits at the far end of a TDM link, feeding per-channel consumers.

Parameters:
- W, 1, data width of each channel sample.
- FCW, 8, width of the completed-frame counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  W  multiplexed sample.
- din_valid  in  1  din carries a sample this cycle.
- frame_sync  in  1  qualifies din as slot 0; ignored when din_valid=0.
- y0, y1, y2, y3  out  W each  reconstructed channel 0..3 from the last complete frame.
- y_valid  out  1  one-cycle pulse: y0..y3 were updated on the previous edge.
- slot  out  2  slot index expected for the next valid sample.
- locked  out  1  high in state LOCK.
- sync_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  FCW  count of completed frames; wraps modulo 2^FCW.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=HUNT; slot=0.
  - Shadow registers s0..s2 and y0..y3 = 0.
  - y_valid=0, sync_err=0, frame_cnt=0.
- A "sample" is a cycle with din_valid=1. Non-sample cycles change nothing, and y_valid/sync_err return to 0.
- HUNT:
  - A sample with frame_sync=0 is discarded; slot stays 0.
  - A sample with frame_sync=1 captures din into s0, sets slot=1 and moves to LOCK.
- LOCK:
  - A sample with frame_sync=0 at slot k (k=0..2) captures din into s_k and sets slot=k+1.
  - A sample at slot 3 with frame_sync=0 completes the frame on that edge:
    - y0<=s0, y1<=s1, y2<=s2, y3<=din.
    - y_valid<=1; frame_cnt increments.
    - slot<=0.
    - Latency: y_valid is high in the cycle after the slot-3 sample edge.
  - frame_sync=1 on a sample at slot 0 is normal operation; the sample is captured into s0.
  - Misplaced sync: frame_sync=1 on a sample at slot 1..3.
    - sync_err<=1.
    - The partial frame is discarded; y0..y3, y_valid and frame_cnt are unchanged.
    - The sample is treated as a new slot 0: din is captured into s0, slot<=1, and the state stays LOCK.
  - A sample at slot 0 with frame_sync=0 is accepted as slot 0 (flywheel), unless the optional feature is enabled.
- Outputs y0..y3 hold their values between frames; they never show a partial frame.
- frame_cnt wraps from 2^FCW-1 to 0 with no flag.
- Reset asserted mid-frame drops all partial data immediately. After release the block is in HUNT and needs a frame_sync before any capture.
- Expected implementation: a 2-state FSM plus a 2-bit slot counter, W-bit shadow registers, and output registers.

Optional Feature:
- Macro: TDM_STRICT_SYNC_EN.
- Defined:
  - In LOCK, a sample at slot 0 must carry frame_sync=1.
  - If it does not: sync_err<=1, the sample is discarded, state<=HUNT, slot<=0, and locked falls on that edge.
  - All other behaviour is as above.
- Undefined: flywheel mode. A missing frame_sync at slot 0 is accepted with no error.

Test Plan:
- Reset, then W=8 samples 0x11(sync),0x22,0x33,0x44 on consecutive cycles -> one cycle after the 0x44 edge: y0..y3=0x11,0x22,0x33,0x44, y_valid=1 for exactly 1 cycle, frame_cnt=1, locked=1.
- In HUNT, samples 0xAA,0xBB with frame_sync=0, then a synced frame 1,2,3,4 -> the 0xAA/0xBB samples are ignored; outputs=1,2,3,4; sync_err never asserted.
- Locked, frame_sync asserted on a slot-2 sample 0x55, then 0x66,0x77,0x88 -> sync_err pulses once; the first y_valid after that shows 0x55,0x66,0x77,0x88; the earlier partial frame never appears on y0..y3.
- Samples interleaved with din_valid=0 gaps of 0-3 cycles -> same outputs as the gap-free case; slot holds during gaps.
- frame_cnt preset path: run 256 frames with FCW=8 -> frame_cnt wraps to 0; rst_n pulled low after slot 1 of a frame -> all outputs 0 at once, locked=0.
- With TDM_STRICT_SYNC_EN: a locked frame whose slot-0 sample lacks frame_sync -> sync_err=1, locked=0, no y_valid. Without the macro, the same stimulus completes the frame normally with no sync_err.
